mc_controller: RTL and testbench

Multicycle MIPS main controller: a Moore FSM that sequences fetch, decode, execute, memory and write-back over several cycles and drives the shared-ALU, single-memory datapath. It supersedes the single-cycle opcode decoder. It adds the following over that decoder:
- registered opcode capture;
- a memory ready/wait handshake;
- illegal-opcode trapping;
- a parametrised ALU-control width.

It sits between the instruction register and the multicycle datapath.

---
 rtl/mips_ctrl_pkg.sv | 51 +++++
 rtl/mc_iop_dec.sv | 21 ++
 rtl/mc_controller.sv | 164 ++++++++++++++++
 tb/tb_mc_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
package mips_ctrl_pkg;

  localparam int unsigned OP_W       = 6;
  localparam int unsigned ALU_CODE_W = 3;
  localparam int unsigned STATE_W    = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IEXEC   = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_e;

  localparam logic [OP_W-1:0] OP_R    = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
  localparam logic [OP_W-1:0] OP_SLTI = 6'b001010;
  localparam logic [OP_W-1:0] OP_J    = 6'b000010;

  localparam logic [ALU_CODE_W-1:0] ALU_AND   = 3'b000;
  localparam logic [ALU_CODE_W-1:0] ALU_OR    = 3'b001;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD   = 3'b010;
  localparam logic [ALU_CODE_W-1:0] ALU_FUNCT = 3'b011;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB   = 3'b110;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT   = 3'b111;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_iop_dec.sv
// I-type ALU decode: selects ALU operation and immediate extension for IEXEC.
module mc_iop_dec
  import mips_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]       op,
  output logic [ALU_CODE_W-1:0] alu_op,
  output logic                  ext_op
);

  always_comb begin
    alu_op = ALU_ADD;
    ext_op = 1'b1;
    case (op)
      OP_ANDI: begin alu_op = ALU_AND; ext_op = 1'b0; end
      OP_ORI:  begin alu_op = ALU_OR;  ext_op = 1'b0; end
      OP_SLTI: begin alu_op = ALU_SLT; ext_op = 1'b1; end
      default: begin alu_op = ALU_ADD; ext_op = 1'b1; end
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM driving the shared-ALU, single-memory datapath.
module mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned ALUOP_W = 3,
  parameter bit          MEM_HS  = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               branch,
  output logic               bne,
  output logic               ir_write,
  output logic               mem_write,
  output logic               reg_write,
  output logic               iord,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_op,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               illegal_op,
  output logic [3:0]         state
);

  state_e                state_q, state_d;
  logic [OP_W-1:0]       op_q;
  logic                  ready;
  logic [ALU_CODE_W-1:0] alu_code;
  logic [ALU_CODE_W-1:0] iop_alu;
  logic                  iop_ext;

  assign ready = MEM_HS ? mem_ready : 1'b1;
  assign state = state_q;

  mc_iop_dec u_iop_dec (
    .op     (op_q),
    .alu_op (iop_alu),
    .ext_op (iop_ext)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= op;
    end
  end

  // DECODE steers on the live opcode; later states only ever see op_q.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                        state_d = S_MEMADR;
          OP_R:                                state_d = S_EXEC;
          OP_BEQ, OP_BNE:                      state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   state_d = S_IEXEC;
          OP_J:                                state_d = S_JUMP;
          default:                             state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (ready) state_d = S_MEMWB;
      S_MEMWR:  if (ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_BRANCH: state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_ALUWB, S_IWB, S_JUMP, S_ILLEGAL: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    bne        = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    ext_op     = 1'b0;
    pc_src     = PCSRC_ALU;
    alu_code   = ALU_AND;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        alu_code  = ALU_ADD;
        pc_write  = ready;
        ir_write  = ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_code  = ALU_ADD;
        ext_op    = 1'b1;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_code  = ALU_ADD;
        ext_op    = 1'b1;
      end
      S_MEMRD:  iord = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_code  = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_code  = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = (op_q == OP_BEQ);
        bne       = (op_q == OP_BNE);
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_code  = iop_alu;
        ext_op    = iop_ext;
      end
      S_IWB:     reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      S_ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
    // Strobes fall with reset_n itself, not on the next edge.
    if (!reset_n) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
    alu_op = ALUOP_W'(alu_code);
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class and checks decoded controls.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, branch, bne, ir_write, mem_write, reg_write;
  logic       iord, mem_to_reg, reg_dst, alu_src_a, ext_op, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  mc_controller #(.ALUOP_W(3), .MEM_HS(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .branch     (branch),
    .bne        (bne),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .iord       (iord),
    .mem_to_reg (mem_to_reg),
    .reg_dst    (reg_dst),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_op     (ext_op),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int mw_cycles;
  int rw_seen;

  initial begin
    reset_n   = 1'b0;
    op        = 6'b000000;
    mem_ready = 1'b1;
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    chk("rst_ir_write", 32'(ir_write), 32'd0);
    chk("rst_alu_src_b", 32'(alu_src_b), 32'b01);
    chk("rst_alu_op", 32'(alu_op), 32'b010);
    chk("rst_op_q", 32'(dut.op_q), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("fetch_pc_write", 32'(pc_write), 32'd1);
    chk("fetch_ir_write", 32'(ir_write), 32'd1);

    // FETCH wait state
    mem_ready = 1'b0;
    #1;
    chk("fetch_wait_pc_write", 32'(pc_write), 32'd0);
    step();
    chk("fetch_wait_state", 32'(state), 32'd0);

    // lw, zero-wait
    mem_ready = 1'b1;
    op = 6'b100011;
    step();
    chk("lw_decode", 32'(state), 32'd1);
    chk("lw_decode_srcb", 32'(alu_src_b), 32'b11);
    chk("lw_decode_ext", 32'(ext_op), 32'd1);
    chk("lw_decode_rw", 32'(reg_write), 32'd0);
    step();
    chk("lw_memadr", 32'(state), 32'd2);
    chk("lw_memadr_ctl", 32'({alu_src_a, alu_src_b, alu_op, ext_op}), 32'b1_10_010_1);
    chk("lw_op_q", 32'(dut.op_q), 32'b100011);
    step();
    chk("lw_memrd", 32'(state), 32'd3);
    chk("lw_memrd_iord", 32'(iord), 32'd1);
    chk("lw_memrd_rw", 32'(reg_write), 32'd0);
    step();
    chk("lw_memwb", 32'(state), 32'd4);
    chk("lw_memwb_ctl", 32'({reg_write, mem_to_reg, reg_dst}), 32'b110);
    step();
    chk("lw_done", 32'(state), 32'd0);

    // sw with two wait cycles in MEMWR
    op = 6'b101011;
    step();
    chk("sw_decode", 32'(state), 32'd1);
    step();
    chk("sw_memadr", 32'(state), 32'd2);
    mem_ready = 1'b0;
    step();
    mw_cycles = 0;
    rw_seen   = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1'b1;
      #1;
      if (state == 4'd5 && mem_write && iord) mw_cycles++;
      if (reg_write) rw_seen++;
      step();
    end
    chk("sw_mem_write_cycles", 32'(mw_cycles), 32'd3);
    chk("sw_no_reg_write", 32'(rw_seen), 32'd0);
    chk("sw_done", 32'(state), 32'd0);

    // bne
    op = 6'b000101;
    step();
    step();
    chk("bne_state", 32'(state), 32'd8);
    chk("bne_ctl", 32'({bne, branch, pc_src, alu_op, alu_src_b}), 32'b1_0_01_110_00);
    step();
    chk("bne_done", 32'(state), 32'd0);

    // beq
    op = 6'b000100;
    step();
    step();
    chk("beq_ctl", 32'({bne, branch, pc_src}), 32'b0_1_01);
    step();

    // andi
    op = 6'b001100;
    step();
    step();
    chk("andi_state", 32'(state), 32'd9);
    chk("andi_ctl", 32'({alu_op, ext_op, alu_src_b, alu_src_a}), 32'b000_0_10_1);
    step();
    chk("andi_iwb", 32'({state, reg_write, reg_dst}), 32'b1010_1_0);
    step();
    chk("andi_done", 32'(state), 32'd0);

    // R-type
    op = 6'b000000;
    step();
    step();
    chk("r_exec", 32'({state, alu_op, alu_src_b, alu_src_a}), 32'b0110_011_00_1);
    step();
    chk("r_aluwb", 32'({state, reg_write, reg_dst}), 32'b0111_1_1);
    step();

    // j
    op = 6'b000010;
    step();
    step();
    chk("j_jump", 32'({state, pc_write, pc_src}), 32'b1011_1_10);
    step();
    chk("j_done", 32'(state), 32'd0);

    // illegal opcode
    op = 6'b111111;
    step();
    chk("ill_decode_strobes", 32'({pc_write, reg_write, mem_write}), 32'd0);
    step();
    chk("ill_state", 32'(state), 32'd12);
    chk("ill_pulse", 32'(illegal_op), 32'd1);
    chk("ill_strobes", 32'({pc_write, reg_write, mem_write, ir_write}), 32'd0);
    step();
    chk("ill_back_fetch", 32'(state), 32'd0);
    chk("ill_pulse_end", 32'(illegal_op), 32'd0);

    // slti, opcode flips to j during IEXEC
    op = 6'b001010;
    step();
    step();
    chk("slti_iexec", 32'({state, alu_op, ext_op}), 32'b1001_111_1);
    op = 6'b000010;
    #1;
    chk("slti_op_change", 32'(alu_op), 32'b111);
    step();
    chk("slti_iwb_not_jump", 32'(state), 32'd10);
    step();

    // reset during MEMWR
    op = 6'b101011;
    step();
    step();
    mem_ready = 1'b0;
    step();
    chk("rst_mid_memwr", 32'({state, mem_write}), 32'b0101_1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mid_state", 32'(state), 32'd0);
    chk("rst_mid_op_q", 32'(dut.op_q), 32'd0);
    step();
    reset_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
